// File: rtl/pic_io_bank.sv
`default_nettype none
// ============================================================================
// Module      : pic_io_bank
// Description : Bank of NUM_PORTS bidirectional WIDTH-bit I/O ports, each with
//               an output latch, a direction register (1 = input) and a
//               two-flop input synchroniser. Reads drive a shared tri-state
//               bus. Optional interrupt-on-change logic is built only when
//               the macro PIC_IO_IOC_EN is defined; otherwise irq is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_io_bank #(
    parameter int NUM_PORTS = 3,
    parameter int WIDTH     = 8,
    parameter int SEL_W     = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         out_en,
    input  logic                         write_en,
    input  logic                         tris_wen,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             data_out,
    inout  wire  [NUM_PORTS*WIDTH-1:0]   dataport,
    output logic                         irq,
    input  logic                         ioc_wen,
    input  logic                         irq_ack
);

    logic [WIDTH-1:0] r_latch [NUM_PORTS];
    logic [WIDTH-1:0] r_tris  [NUM_PORTS];
    logic [WIDTH-1:0] r_sync1 [NUM_PORTS];
    logic [WIDTH-1:0] r_sync2 [NUM_PORTS];
    logic [WIDTH-1:0] w_rd;

    // Latch/direction writes and pad synchronisers; out-of-range sel matches no port
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_latch[p] <= '0;
                r_tris[p]  <= '1;
                r_sync1[p] <= '0;
                r_sync2[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (write_en && (sel == SEL_W'(p))) begin
                    r_latch[p] <= data_in;
                end
                if (tris_wen && (sel == SEL_W'(p))) begin
                    r_tris[p] <= data_in;
                end
                r_sync1[p] <= dataport[p*WIDTH +: WIDTH];
                r_sync2[p] <= r_sync1[p];
            end
        end
    end

    // Each pad bit is driven from its latch only while configured as an output
    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
        for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
            assign dataport[gp*WIDTH + gb] = r_tris[gp][gb] ? 1'bz : r_latch[gp][gb];
        end
    end

    // Read mux over synchronised pad values; unmatched sel reads zero
    always_comb begin
        w_rd = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (sel == SEL_W'(p)) begin
                w_rd = r_sync2[p];
            end
        end
    end

    assign data_out = out_en ? w_rd : {WIDTH{1'bz}};

`ifdef PIC_IO_IOC_EN
    logic [NUM_PORTS-1:0] r_ioc_en;
    logic [NUM_PORTS-1:0] r_pending;
    logic [NUM_PORTS-1:0] w_change;
    logic [WIDTH-1:0]     r_prev [NUM_PORTS];
    logic [1:0]           r_settle;
    logic                 r_irq;

    // A change counts only on input bits of an enabled port once the synchronisers have refilled
    always_comb begin
        w_change = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_change[p] = r_ioc_en[p] && (r_settle == 2'd3) &&
                          (|((r_sync2[p] ^ r_prev[p]) & r_tris[p]));
        end
    end

    // Change-enable bits, pending flags (set wins over ack) and registered irq
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ioc_en  <= '0;
            r_pending <= '0;
            r_settle  <= 2'd0;
            r_irq     <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_prev[p] <= '0;
            end
        end else begin
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
            r_irq <= |r_pending;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_prev[p] <= r_sync2[p];
                if (ioc_wen && (sel == SEL_W'(p))) begin
                    r_ioc_en[p] <= data_in[0];
                end
                if (w_change[p]) begin
                    r_pending[p] <= 1'b1;
                end else if (irq_ack && (sel == SEL_W'(p))) begin
                    r_pending[p] <= 1'b0;
                end
            end
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_ioc;

    assign w_unused_ioc = ^{ioc_wen, irq_ack};
    assign irq          = 1'b0;
`endif

endmodule
`default_nettype wire
